ysyx_23060236_lsu: RTL and testbench
====================================

YSYX_23060236_LSU -- requirements
Module: ysyx_23060236_lsu

Interface
REQ-001 clock  in  1  single clock; all state updates on posedge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-003 lsu_valid  in  1  request from execute stage.
REQ-004 lsu_ready  out  1  high only in IDLE; request accepted when lsu_valid & lsu_ready at a posedge.
REQ-005 ren / wen  in  1 / 1  load / store request; both low = no-memory op; never both high.
REQ-006 funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  in  32  byte address; also the pass-through result for no-memory ops.
REQ-008 wdata_in  in  32  store data, right-aligned.
REQ-009 lsu_over  out  1  one-cycle completion pulse.
REQ-010 lsu_rdata  out  32  extended load data, or latched addr for no-memory ops; valid while lsu_over=1.
REQ-011 lsu_err  out  1  valid with lsu_over; 1 = misaligned access or bus resp != 2'b00.
REQ-012 AXI4-lite master: araddr 32, arvalid, arready, rdata 32, rresp 2, rvalid, rready, awaddr 32, awvalid, awready, wdata 32, wstrb 4, wvalid, wready, bresp 2, bvalid, bready.

Function
REQ-013 States: IDLE, AR, R, AW_W, B, DONE.
REQ-014 On acceptance, addr, funct3, ren, wen, wdata_in latched; inputs ignored until next IDLE.
REQ-015 Acceptance transitions: misaligned (H with addr[0]=1, W with addr[1:0]!=0) -> DONE, err=1, no bus traffic; ren -> AR; wen -> AW_W; neither -> DONE.
REQ-016 AR: arvalid=1, araddr = latched addr, held stable until arready; arvalid&arready -> R.
REQ-017 R: rready=1; rvalid -> DONE, err = (rresp!=0).
REQ-018 AW_W: awvalid and wvalid asserted together on entry; each drops after its own handshake; both complete (same or different cycles) -> B.
REQ-019 Store lanes: wdata = wdata_in << 8*addr[1:0]; wstrb = (B 4'b0001, H 4'b0011, W 4'b1111) << addr[1:0]; awaddr = addr.
REQ-020 B: bready=1; bvalid -> DONE, err = (bresp!=0).
REQ-021 DONE: exactly one cycle; lsu_over=1; next state IDLE; lsu_ready=0 during DONE.
REQ-022 Load data: s = rdata >> 8*addr[1:0]; B sign-extends s[7:0], H sign-extends s[15:0], BU/HU zero-extend, W = rdata; captured at R handshake.
REQ-023 Store completion: lsu_rdata = 0.
REQ-024 Minimum latency, accept to lsu_over: no-memory/misaligned 1 cycle; load with arready and rvalid each immediate 3 cycles; store 3 cycles.
REQ-025 Backpressure: any number of cycles without arready/rvalid/awready/wready/bvalid holds state and all outputs unchanged.
REQ-026 Only one outstanding transaction; no new request accepted before DONE -> IDLE.

Reset
REQ-027 On reset, asynchronously: state IDLE; lsu_over, lsu_err, arvalid, rready, awvalid, wvalid, bready = 0; lsu_ready = 1 after deassertion; lsu_rdata, addresses, wdata, wstrb = 0.
REQ-028 Reset mid-transaction aborts it; no lsu_over is issued for the aborted request.

Verification
REQ-029 LB at addr 0x8000_0003, rdata 0x80FF_FF12, immediate ready/valid -> araddr 0x8000_0003; lsu_rdata 0xFFFF_FF80, err 0; lsu_over 3 cycles after accept.
REQ-030 SH at 0x8000_0002, wdata_in 0x0000_BEEF; awready 2 cycles late, wready immediate -> wdata 0xBEEF_0000, wstrb 4'b1100; awvalid held until handshake; one lsu_over pulse.
REQ-031 LW at 0x8000_0001 -> no arvalid; lsu_over next cycle, err 1.
REQ-032 No-memory op, addr 0x1234_5678 -> lsu_over next cycle; lsu_rdata 0x1234_5678; err 0; no bus activity.
REQ-033 LHU with rresp 2'b10 and rvalid delayed 5 cycles -> rready held high; lsu_err 1 on lsu_over.
REQ-034 Reset asserted while in R -> rready drops in the same cycle; no lsu_over; lsu_ready=1 after deassertion; next request completes normally.

Source files
------------

// File: rtl/ysyx_23060236_lsu.sv
// Load/store unit: accepts one memory request at a time from execute and
// runs it over an AXI4-lite master port, returning aligned/extended load data.
//
// state | meaning
// IDLE  | ready for a new request
// AR    | read address presented, waiting for arready
// R     | waiting for read data
// AW_W  | write address and data presented, waiting for both handshakes
// B     | waiting for write response
// DONE  | one-cycle completion pulse on lsu_over
module ysyx_23060236_lsu (
    input  logic        clock,
    input  logic        reset,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic        ren,
    input  logic        wen,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_in,
    output logic        lsu_over,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  funct3_q;
    logic        misaligned;
    logic [3:0]  strb_base;
    logic [31:0] load_data;
    logic [31:0] rdata_sh;

    always_comb begin
        misaligned = 1'b0;
        strb_base  = 4'b1111;
        case (funct3[1:0])
            2'b00: strb_base = 4'b0001;
            2'b01: begin
                strb_base  = 4'b0011;
                misaligned = addr[0];
            end
            2'b10: misaligned = (addr[1:0] != 2'b00);
            default: ;
        endcase
    end

    // Shift the addressed byte lane down to bit 0 before extension.
    always_comb begin
        rdata_sh  = rdata >> {off_q, 3'b000};
        load_data = rdata;
        case (funct3_q)
            3'b000: load_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001: load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100: load_data = {24'd0, rdata_sh[7:0]};
            3'b101: load_data = {16'd0, rdata_sh[15:0]};
            default: load_data = rdata;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            off_q     <= 2'b00;
            funct3_q  <= 3'b000;
            lsu_ready <= 1'b1;
            lsu_over  <= 1'b0;
            lsu_err   <= 1'b0;
            lsu_rdata <= 32'd0;
            araddr    <= 32'd0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= 32'd0;
            awvalid   <= 1'b0;
            wdata     <= 32'd0;
            wstrb     <= 4'b0000;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_valid) begin
                        lsu_ready <= 1'b0;
                        off_q     <= addr[1:0];
                        funct3_q  <= funct3;
                        if ((ren || wen) && misaligned) begin
                            state     <= DONE;
                            lsu_over  <= 1'b1;
                            lsu_err   <= 1'b1;
                            lsu_rdata <= 32'd0;
                        end else if (ren) begin
                            state   <= AR;
                            arvalid <= 1'b1;
                            araddr  <= addr;
                        end else if (wen) begin
                            state   <= AW_W;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            awaddr  <= addr;
                            wdata   <= wdata_in << {addr[1:0], 3'b000};
                            wstrb   <= strb_base << addr[1:0];
                        end else begin
                            state     <= DONE;
                            lsu_over  <= 1'b1;
                            lsu_err   <= 1'b0;
                            lsu_rdata <= addr;
                        end
                    end
                end
                AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        lsu_rdata <= load_data;
                        lsu_err   <= (rresp != 2'b00);
                        lsu_over  <= 1'b1;
                        state     <= DONE;
                    end
                end
                AW_W: begin
                    // Address and data channels complete independently.
                    if (awready) awvalid <= 1'b0;
                    if (wready)  wvalid  <= 1'b0;
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        lsu_err   <= (bresp != 2'b00);
                        lsu_rdata <= 32'd0;
                        lsu_over  <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    lsu_over  <= 1'b0;
                    lsu_err   <= 1'b0;
                    lsu_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_lsu.sv
// Directed bench for ysyx_23060236_lsu: loads, stores, misaligned, pass-through,
// backpressure and reset abort, each checked against hand-computed values.
module tb_ysyx_23060236_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata_in = 32'd0;
    logic        lsu_over;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ysyx_23060236_lsu dut (
        .clock(clock), .reset(reset),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .ren(ren), .wen(wen), .funct3(funct3), .addr(addr), .wdata_in(wdata_in),
        .lsu_over(lsu_over), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic r, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
        lsu_valid = 1'b1; ren = r; wen = w; funct3 = f3; addr = a; wdata_in = wd;
    endtask

    task automatic drop_req();
        lsu_valid = 1'b0; ren = 1'b0; wen = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst_lsu_over", 32'(lsu_over), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wstrb", 32'(wstrb), 32'd0);
        chk("rst_lsu_rdata", lsu_rdata, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready", 32'(lsu_ready), 32'd1);

        // LB at 0x8000_0003, immediate ready/valid
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h80FF_FF12; rresp = 2'b00;
        req(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0);
        tick(); drop_req();
        chk("lb_arvalid", 32'(arvalid), 32'd1);
        chk("lb_araddr", araddr, 32'h8000_0003);
        chk("lb_busy", 32'(lsu_ready), 32'd0);
        chk("lb_over_c1", 32'(lsu_over), 32'd0);
        tick();
        chk("lb_rready", 32'(rready), 32'd1);
        chk("lb_arvalid_drop", 32'(arvalid), 32'd0);
        chk("lb_over_c2", 32'(lsu_over), 32'd0);
        tick();
        chk("lb_over", 32'(lsu_over), 32'd1);
        chk("lb_rdata", lsu_rdata, 32'hFFFF_FF80);
        chk("lb_err", 32'(lsu_err), 32'd0);
        chk("lb_done_ready", 32'(lsu_ready), 32'd0);
        arready = 1'b0; rvalid = 1'b0;
        tick();
        chk("lb_over_end", 32'(lsu_over), 32'd0);
        chk("lb_ready_back", 32'(lsu_ready), 32'd1);

        // SH at 0x8000_0002, awready two cycles late, wready immediate
        wready = 1'b1; awready = 1'b0;
        req(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF);
        tick(); drop_req();
        chk("sh_awvalid", 32'(awvalid), 32'd1);
        chk("sh_wvalid", 32'(wvalid), 32'd1);
        chk("sh_awaddr", awaddr, 32'h8000_0002);
        chk("sh_wdata", wdata, 32'hBEEF_0000);
        chk("sh_wstrb", 32'(wstrb), 32'h0000_000C);
        tick();
        wready = 1'b0;
        chk("sh_wvalid_drop", 32'(wvalid), 32'd0);
        chk("sh_awvalid_hold1", 32'(awvalid), 32'd1);
        chk("sh_awaddr_hold1", awaddr, 32'h8000_0002);
        tick();
        chk("sh_awvalid_hold2", 32'(awvalid), 32'd1);
        chk("sh_bready_early", 32'(bready), 32'd0);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("sh_awvalid_drop", 32'(awvalid), 32'd0);
        chk("sh_bready", 32'(bready), 32'd1);
        chk("sh_over_early", 32'(lsu_over), 32'd0);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("sh_over", 32'(lsu_over), 32'd1);
        chk("sh_err", 32'(lsu_err), 32'd0);
        chk("sh_rdata", lsu_rdata, 32'd0);
        chk("sh_bready_drop", 32'(bready), 32'd0);
        tick();
        chk("sh_over_single", 32'(lsu_over), 32'd0);

        // SB at 0x8000_0001, all channels immediate: 3-cycle latency
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        req(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_56A5);
        tick(); drop_req();
        chk("sb_wdata", wdata, 32'h3456_A500);
        chk("sb_wstrb", 32'(wstrb), 32'h0000_0002);
        tick();
        chk("sb_over_c2", 32'(lsu_over), 32'd0);
        tick();
        chk("sb_over", 32'(lsu_over), 32'd1);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        tick();

        // Misaligned LW at 0x8000_0001: no bus traffic, error next cycle
        arready = 1'b1;
        req(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'd0);
        tick(); drop_req();
        chk("mis_arvalid", 32'(arvalid), 32'd0);
        chk("mis_over", 32'(lsu_over), 32'd1);
        chk("mis_err", 32'(lsu_err), 32'd1);
        arready = 1'b0;
        tick();
        chk("mis_over_end", 32'(lsu_over), 32'd0);
        chk("mis_err_end", 32'(lsu_err), 32'd0);

        // No-memory op: address passes through
        req(1'b0, 1'b0, 3'b010, 32'h1234_5678, 32'hFFFF_FFFF);
        tick(); drop_req();
        chk("nop_over", 32'(lsu_over), 32'd1);
        chk("nop_rdata", lsu_rdata, 32'h1234_5678);
        chk("nop_err", 32'(lsu_err), 32'd0);
        chk("nop_bus", {30'd0, arvalid, awvalid}, 32'd0);
        tick();

        // LHU at 0x8000_0002, rvalid 5 cycles late with SLVERR
        arready = 1'b1;
        req(1'b1, 1'b0, 3'b101, 32'h8000_0002, 32'd0);
        tick(); drop_req();
        tick();
        arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("lhu_rready_hold", 32'(rready), 32'd1);
            chk("lhu_over_wait", 32'(lsu_over), 32'd0);
            tick();
        end
        rvalid = 1'b1; rresp = 2'b10; rdata = 32'hABCD_1234;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        chk("lhu_over", 32'(lsu_over), 32'd1);
        chk("lhu_err", 32'(lsu_err), 32'd1);
        chk("lhu_rdata", lsu_rdata, 32'h0000_ABCD);
        tick();

        // LH at 0x8000_0000, sign extension of lower half
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_8001;
        req(1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'd0);
        tick(); drop_req();
        tick(); tick();
        chk("lh_over", 32'(lsu_over), 32'd1);
        chk("lh_rdata", lsu_rdata, 32'hFFFF_8001);
        arready = 1'b0; rvalid = 1'b0;
        tick();

        // Reset while in R aborts the load
        arready = 1'b1;
        req(1'b1, 1'b0, 3'b100, 32'h8000_0000, 32'd0);
        tick(); drop_req();
        tick();
        arready = 1'b0;
        chk("abort_in_r", 32'(rready), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_rready", 32'(rready), 32'd0);
        rvalid = 1'b1; rdata = 32'h0000_00AA;
        tick();
        chk("abort_over_rst", 32'(lsu_over), 32'd0);
        reset = 1'b0;
        tick();
        chk("abort_over_after", 32'(lsu_over), 32'd0);
        chk("abort_ready", 32'(lsu_ready), 32'd1);
        rvalid = 1'b0;

        // Normal LW after the abort
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1122_3344;
        req(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'd0);
        tick(); drop_req();
        chk("lw_araddr", araddr, 32'h8000_0004);
        tick(); tick();
        chk("lw_over", 32'(lsu_over), 32'd1);
        chk("lw_rdata", lsu_rdata, 32'h1122_3344);
        chk("lw_err", 32'(lsu_err), 32'd0);
        arready = 1'b0; rvalid = 1'b0;
        tick();
        chk("lw_ready_back", 32'(lsu_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
